// File: rtl/fifo_pkg.sv
// fifo_pkg: mode constants and width helper shared by the width-converting FIFO.
package fifo_pkg;
    localparam int FIFO_STD = 0;
    localparam int FIFO_FWFT = 1;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/fifo_sync_wc_if.sv
// fifo_sync_wc_if: write/read handshake, status and error signals of the width-converting FIFO.
interface fifo_sync_wc_if
    import fifo_pkg::*;
#(
    parameter int data_width = 16,
    parameter int ratio = 4,
    parameter int addr_width = 4
);
    localparam int cw = addr_width + clog2(ratio) + 1;
    logic clr, wr_en, rd_en, valid, empty, full, almost_full, almost_empty, overflow, underflow;
    logic [data_width*ratio-1:0] din;
    logic [data_width-1:0] dout;
    logic [cw-1:0] count;
    modport master (
        output clr, wr_en, din, rd_en,
        input valid, dout, empty, full, almost_full, almost_empty, count, overflow, underflow
    );
    modport slave (
        input clr, wr_en, din, rd_en,
        output valid, dout, empty, full, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_dpram.sv
// fifo_dpram: one-write/one-read RAM on clk with selectable synchronous or asynchronous read.
module fifo_dpram #(
    parameter int width = 64,
    parameter int addr_width = 4,
    parameter bit async_rd = 1'b0
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [width-1:0]      wdata,
    input  logic [addr_width-1:0] raddr,
    output logic [width-1:0]      rdata
);
    logic [width-1:0] mem [1<<addr_width];
    always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
    generate
        if (async_rd) begin : g_async
            assign rdata = mem[raddr];
        end else begin : g_sync
            logic [width-1:0] rdata_q;
            always_ff @(posedge clk) rdata_q <= mem[raddr];
            assign rdata = rdata_q;
        end
    endgenerate
endmodule

// File: rtl/fifo_sync_wc.sv
// fifo_sync_wc: single-clock FIFO storing ratio-packed wide words and returning one narrow word per read.
module fifo_sync_wc
    import fifo_pkg::*;
#(
    parameter int data_width = 16,
    parameter int ratio = 4,
    parameter int addr_width = 4,
    parameter int fwft = FIFO_STD,
    parameter int af_level = (1 << addr_width) - 1,
    parameter int ae_level = 1
) (
    input logic clk,
    input logic rst_n,
    fifo_sync_wc_if.slave bus
);
    localparam int depth = 1 << addr_width;
    localparam int sw = clog2(ratio);
    localparam int sel_w = sw > 0 ? sw : 1;
    localparam int cw = addr_width + sw + 1;
    localparam logic [addr_width:0] af_l = (addr_width+1)'(af_level);
    localparam logic [cw-1:0] ae_l = cw'(ae_level);
    localparam logic [sel_w-1:0] sel_last = sel_w'(ratio - 1);
    logic [addr_width:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, entries;
    logic [sel_w-1:0] sel_q, sel_d, rsel_q, rsel_d, psel;
    logic valid_q, valid_d, overflow_q, overflow_d, underflow_q, underflow_d;
    logic full, empty, wr_acc, rd_acc, pop_entry, out_valid;
    logic [cw-1:0] count;
    logic [data_width*ratio-1:0] rdata;
    logic [data_width-1:0] slice;
    fifo_dpram #(
        .width(data_width * ratio),
        .addr_width(addr_width),
        .async_rd(fwft == FIFO_FWFT)
    ) u_ram (
        .clk(clk),
        .we(wr_acc),
        .waddr(wr_ptr_q[addr_width-1:0]),
        .wdata(bus.din),
        .raddr(rd_ptr_q[addr_width-1:0]),
        .rdata(rdata)
    );
    always_comb begin
        entries = wr_ptr_q - rd_ptr_q;
        full = entries == (addr_width+1)'(depth);
        empty = entries == '0;
        wr_acc = bus.wr_en && !full;
        rd_acc = bus.rd_en && !empty;
        pop_entry = rd_acc && sel_q == sel_last;
        count = (cw'(entries) << sw) - cw'(sel_q);
        wr_ptr_d = bus.clr ? '0 : wr_ptr_q + (addr_width+1)'(wr_acc);
        rd_ptr_d = bus.clr ? '0 : rd_ptr_q + (addr_width+1)'(pop_entry);
        sel_d = bus.clr || pop_entry ? '0 : sel_q + sel_w'(rd_acc);
        rsel_d = rd_acc ? sel_q : rsel_q;
        valid_d = !bus.clr && rd_acc;
        overflow_d = !bus.clr && (overflow_q || (bus.wr_en && full));
        underflow_d = !bus.clr && (underflow_q || (bus.rd_en && empty));
        // registered mode picks the slice latched alongside the synchronous RAM read
        psel = fwft == FIFO_FWFT ? sel_q : rsel_q;
        slice = rdata[psel*data_width +: data_width];
        out_valid = fwft == FIFO_FWFT ? !empty : valid_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sel_q <= '0;
            rsel_q <= '0;
            valid_q <= 1'b0;
            overflow_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sel_q <= sel_d;
            rsel_q <= rsel_d;
            valid_q <= valid_d;
            overflow_q <= overflow_d;
            underflow_q <= underflow_d;
        end
    end
    assign bus.valid = out_valid;
    assign bus.dout = out_valid ? slice : '0;
    assign bus.empty = empty;
    assign bus.full = full;
    assign bus.almost_full = entries >= af_l;
    assign bus.almost_empty = count <= ae_l;
    assign bus.count = count;
    assign bus.overflow = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_fifo_sync_wc.sv
// tb_fifo_sync_wc: scoreboard bench driving a registered-read and a fall-through instance side by side.
module tb_fifo_sync_wc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_run = 0;
    int n_fail = 0;
    logic [7:0] qs[$];
    logic [7:0] qf[$];
    logic [7:0] exp;
    logic [31:0] w;
    always #5 clk = ~clk;
    fifo_sync_wc_if #(.data_width(8), .ratio(4), .addr_width(2)) bs ();
    fifo_sync_wc_if #(.data_width(8), .ratio(4), .addr_width(2)) bf ();
    fifo_sync_wc #(.data_width(8), .ratio(4), .addr_width(2), .fwft(0), .af_level(3), .ae_level(1))
        u_std (.clk(clk), .rst_n(rst_n), .bus(bs));
    fifo_sync_wc #(.data_width(8), .ratio(4), .addr_width(2), .fwft(1), .af_level(3), .ae_level(1))
        u_fwft (.clk(clk), .rst_n(rst_n), .bus(bf));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push_s(input logic [31:0] v);
        for (int i = 0; i < 4; i++) qs.push_back(v[i*8 +: 8]);
    endtask

    task automatic wr_s(input logic [31:0] v);
        bs.wr_en = 1'b1; bs.din = v; push_s(v);
        step;
        bs.wr_en = 1'b0;
    endtask

    task automatic clear_s;
        bs.clr = 1'b1; step; bs.clr = 1'b0; qs.delete();
    endtask

    task automatic test_reset;
        {bs.clr, bs.wr_en, bs.rd_en, bf.clr, bf.wr_en, bf.rd_en} = '0;
        bs.din = '0; bf.din = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step;
        n_run++; if (bs.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %0h want 1", bs.empty); end
        n_run++; if (bs.almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_almost_empty got %0h want 1", bs.almost_empty); end
        n_run++; if (bs.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0h want 0", bs.full); end
        n_run++; if (bs.count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bs.count); end
        n_run++; if (bs.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0h want 0", bs.valid); end
        n_run++; if (bs.dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %0h want 00", bs.dout); end
        n_run++; if (bf.valid !== 1'b0) begin n_fail++; $display("FAIL reset_fwft_valid got %0h want 0", bf.valid); end
    endtask

    task automatic test_std_read;
        wr_s(32'h44332211);
        n_run++; if (bs.count !== 5'd4) begin n_fail++; $display("FAIL std_count_wr got %0d want 4", bs.count); end
        n_run++; if (bs.valid !== 1'b0) begin n_fail++; $display("FAIL std_valid_idle got %0h want 0", bs.valid); end
        bs.rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step;
            exp = qs.pop_front();
            n_run++; if (bs.valid !== 1'b1) begin n_fail++; $display("FAIL std_valid[%0d] got %0h want 1", i, bs.valid); end
            n_run++; if (bs.dout !== exp) begin n_fail++; $display("FAIL std_dout[%0d] got %0h want %0h", i, bs.dout, exp); end
            n_run++; if (bs.count !== 5'(3 - i)) begin n_fail++; $display("FAIL std_count[%0d] got %0d want %0d", i, bs.count, 3 - i); end
        end
        bs.rd_en = 1'b0;
        n_run++; if (bs.empty !== 1'b1) begin n_fail++; $display("FAIL std_empty_after got %0h want 1", bs.empty); end
        step;
        n_run++; if (bs.valid !== 1'b0 || bs.dout !== 8'h00) begin n_fail++; $display("FAIL std_idle valid=%0h dout=%0h want 0/00", bs.valid, bs.dout); end
    endtask

    task automatic test_full;
        for (int i = 0; i < 4; i++) begin
            wr_s($urandom());
            n_run++; if (bs.almost_full !== (i >= 2)) begin n_fail++; $display("FAIL af_after_wr[%0d] got %0h want %0h", i, bs.almost_full, i >= 2); end
            n_run++; if (bs.full !== (i == 3)) begin n_fail++; $display("FAIL full_after_wr[%0d] got %0h want %0h", i, bs.full, i == 3); end
        end
        n_run++; if (bs.count !== 5'd16) begin n_fail++; $display("FAIL full_count got %0d want 16", bs.count); end
        bs.wr_en = 1'b1; bs.din = $urandom();
        step;
        bs.wr_en = 1'b0;
        n_run++; if (bs.overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set got %0h want 1", bs.overflow); end
        n_run++; if (bs.count !== 5'd16) begin n_fail++; $display("FAIL overflow_count got %0d want 16", bs.count); end
        bs.rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step;
            exp = qs.pop_front();
            n_run++; if (bs.valid !== 1'b1 || bs.dout !== exp) begin n_fail++; $display("FAIL full_drain[%0d] valid=%0h dout=%0h want 1/%0h", i, bs.valid, bs.dout, exp); end
            n_run++; if (i < 4 && bs.full !== (i < 3)) begin n_fail++; $display("FAIL full_hold[%0d] got %0h want %0h", i, bs.full, i < 3); end
        end
        bs.rd_en = 1'b0;
        n_run++; if (bs.empty !== 1'b1 || bs.overflow !== 1'b1) begin n_fail++; $display("FAIL full_end empty=%0h overflow=%0h want 1/1", bs.empty, bs.overflow); end
        clear_s;
        n_run++; if (bs.overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_clr got %0h want 0", bs.overflow); end
    endtask

    task automatic test_simul;
        for (int i = 0; i < 4; i++) wr_s($urandom());
        bs.wr_en = 1'b1; bs.rd_en = 1'b1; bs.din = $urandom();
        step;
        bs.wr_en = 1'b0;
        exp = qs.pop_front();
        n_run++; if (bs.valid !== 1'b1 || bs.dout !== exp) begin n_fail++; $display("FAIL simul_full_rd valid=%0h dout=%0h want 1/%0h", bs.valid, bs.dout, exp); end
        n_run++; if (bs.overflow !== 1'b1) begin n_fail++; $display("FAIL simul_full_ovf got %0h want 1", bs.overflow); end
        n_run++; if (bs.count !== 5'd15) begin n_fail++; $display("FAIL simul_full_count got %0d want 15", bs.count); end
        for (int i = 0; i < 15; i++) begin
            step;
            exp = qs.pop_front();
            n_run++; if (bs.dout !== exp) begin n_fail++; $display("FAIL simul_drain[%0d] got %0h want %0h", i, bs.dout, exp); end
        end
        bs.rd_en = 1'b0;
        clear_s;
        w = $urandom();
        bs.wr_en = 1'b1; bs.rd_en = 1'b1; bs.din = w; push_s(w);
        step;
        bs.wr_en = 1'b0; bs.rd_en = 1'b0;
        n_run++; if (bs.underflow !== 1'b1) begin n_fail++; $display("FAIL simul_empty_udf got %0h want 1", bs.underflow); end
        n_run++; if (bs.count !== 5'd4) begin n_fail++; $display("FAIL simul_empty_count got %0d want 4", bs.count); end
        n_run++; if (bs.valid !== 1'b0) begin n_fail++; $display("FAIL simul_empty_valid got %0h want 0", bs.valid); end
        bs.rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step;
            exp = qs.pop_front();
            n_run++; if (bs.dout !== exp) begin n_fail++; $display("FAIL simul_empty_drain[%0d] got %0h want %0h", i, bs.dout, exp); end
        end
        bs.rd_en = 1'b0;
        clear_s;
    endtask

    task automatic test_back_to_back;
        bs.wr_en = 1'b1; w = $urandom(); bs.din = w; push_s(w);
        step;
        for (int i = 1; i <= 16; i++) begin
            bs.rd_en = 1'b1;
            bs.wr_en = i < 4;
            if (i < 4) begin w = $urandom(); bs.din = w; push_s(w); end
            step;
            exp = qs.pop_front();
            n_run++; if (bs.valid !== 1'b1 || bs.dout !== exp) begin n_fail++; $display("FAIL b2b[%0d] valid=%0h dout=%0h want 1/%0h", i, bs.valid, bs.dout, exp); end
        end
        bs.wr_en = 1'b0; bs.rd_en = 1'b0;
        n_run++; if (bs.empty !== 1'b1 || bs.overflow !== 1'b0 || bs.underflow !== 1'b0) begin n_fail++; $display("FAIL b2b_end empty=%0h ovf=%0h udf=%0h want 1/0/0", bs.empty, bs.overflow, bs.underflow); end
    endtask

    task automatic test_fwft;
        w = 32'hDDCCBBAA;
        bf.wr_en = 1'b1; bf.din = w;
        for (int i = 0; i < 4; i++) qf.push_back(w[i*8 +: 8]);
        step;
        bf.wr_en = 1'b0;
        n_run++; if (bf.valid !== 1'b1 || bf.dout !== qf[0]) begin n_fail++; $display("FAIL fwft_first valid=%0h dout=%0h want 1/%0h", bf.valid, bf.dout, qf[0]); end
        n_run++; if (bf.count !== 5'd4) begin n_fail++; $display("FAIL fwft_count got %0d want 4", bf.count); end
        bf.rd_en = 1'b1; void'(qf.pop_front());
        step;
        bf.rd_en = 1'b0;
        n_run++; if (bf.dout !== qf[0]) begin n_fail++; $display("FAIL fwft_second got %0h want %0h", bf.dout, qf[0]); end
        for (int i = 0; i < 8 && bf.valid === 1'b1 && qf.size() > 0; i++) begin
            exp = qf.pop_front();
            n_run++; if (bf.dout !== exp) begin n_fail++; $display("FAIL fwft_drain[%0d] got %0h want %0h", i, bf.dout, exp); end
            bf.rd_en = 1'b1;
            step;
            bf.rd_en = 1'b0;
        end
        n_run++; if (bf.valid !== 1'b0 || qf.size() != 0) begin n_fail++; $display("FAIL fwft_end valid=%0h left=%0d want 0/0", bf.valid, qf.size()); end
    endtask

    task automatic test_clr;
        bs.rd_en = 1'b1; step; bs.rd_en = 1'b0;
        n_run++; if (bs.underflow !== 1'b1) begin n_fail++; $display("FAIL clr_pre_udf got %0h want 1", bs.underflow); end
        wr_s($urandom());
        wr_s($urandom());
        bs.clr = 1'b1; bs.wr_en = 1'b1; bs.din = $urandom();
        step;
        bs.clr = 1'b0; bs.wr_en = 1'b0; qs.delete();
        n_run++; if (bs.empty !== 1'b1 || bs.count !== 5'd0) begin n_fail++; $display("FAIL clr_state empty=%0h count=%0d want 1/0", bs.empty, bs.count); end
        n_run++; if (bs.underflow !== 1'b0 || bs.overflow !== 1'b0 || bs.almost_empty !== 1'b1) begin n_fail++; $display("FAIL clr_flags udf=%0h ovf=%0h ae=%0h want 0/0/1", bs.underflow, bs.overflow, bs.almost_empty); end
    endtask

    task automatic test_reset_mid;
        wr_s($urandom());
        bs.rd_en = 1'b1;
        wr_s($urandom());
        wr_s($urandom());
        n_run++; if (bs.valid !== 1'b1 || bs.count === 5'd0) begin n_fail++; $display("FAIL mid_pre valid=%0h count=%0d want 1/nonzero", bs.valid, bs.count); end
        bs.wr_en = 1'b1; bs.din = $urandom();
        rst_n = 1'b0;
        #1;
        n_run++; if (bs.empty !== 1'b1 || bs.count !== 5'd0 || bs.full !== 1'b0) begin n_fail++; $display("FAIL mid_rst empty=%0h count=%0d full=%0h want 1/0/0", bs.empty, bs.count, bs.full); end
        n_run++; if (bs.valid !== 1'b0 || bs.dout !== 8'h00) begin n_fail++; $display("FAIL mid_rst_out valid=%0h dout=%0h want 0/00", bs.valid, bs.dout); end
        bs.wr_en = 1'b0; bs.rd_en = 1'b0; qs.delete();
        #2 rst_n = 1'b1;
        step;
        n_run++; if (bs.empty !== 1'b1 || bs.almost_full !== 1'b0) begin n_fail++; $display("FAIL mid_rel empty=%0h af=%0h want 1/0", bs.empty, bs.almost_full); end
    endtask

    initial begin
        test_reset;
        test_std_read;
        test_full;
        test_simul;
        test_back_to_back;
        test_fwft;
        test_clr;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end
endmodule
